// File: rtl/fusion_row_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fusion_row_sequencer
//  Purpose  : Frame-level controller for the combinational 64-pixel fusion
//             datapath. On start it walks rows 0..ROWS-1: reads the image and
//             overlay rows (shared address), holds both rows stable at the
//             fusion inputs, writes the fused row to the frame buffer under a
//             ready handshake, and pulses done at frame end.
//  Ports    : clk, rst_n            clock / async active-low reset
//             start                 1-cycle frame request (IDLE only)
//             busy, done            status (busy outside IDLE, done pulse)
//             rd_en, rd_addr        read strobe/address to both memories
//             img_rdata, ovl_rdata  memory read data (valid RD_LAT after rd_en)
//             fus_img, fus_ovl      registered rows into the fusion datapath
//             fus_result            fused row from the datapath
//             wr_en, wr_addr,       frame-buffer write request, address, data
//             wr_data, wr_ready     and ready
//  Revision : 1.0  initial release
// ============================================================================
module fusion_row_sequencer #(
  parameter int ROWS   = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 512,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] img_rdata,
  input  logic [DATA_W-1:0] ovl_rdata,
  output logic [DATA_W-1:0] fus_img,
  output logic [DATA_W-1:0] fus_ovl,
  input  logic [DATA_W-1:0] fus_result,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready
);

  // Wait counter only needs to hold RD_LAT-1.
  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  c_cnt_init = CNT_W'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] c_last_row = ADDR_W'(ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_row;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_fus_img;
  logic [DATA_W-1:0] r_fus_ovl;

  logic w_accept;
  logic w_last_row;
  logic w_capture;

  assign w_accept   = (r_state == S_WR) && wr_ready;
  assign w_last_row = (r_row == c_last_row);
  // Read data is valid in the final WAIT cycle; latch it at that edge.
  assign w_capture  = (r_state == S_WAIT) && (r_cnt == '0);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and outputs. All control outputs decode from the state only,
  // so an asynchronous reset clears them without waiting for a clock edge.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    done        = 1'b0;
    rd_en       = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_RD;
        end
      end
      S_RD: begin
        rd_en       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        wr_en   = 1'b1;
        // Gated so the write bus is quiet (and zero in reset) outside WR.
        wr_data = fus_result;
        if (wr_ready) begin
          w_state_nxt = w_last_row ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign rd_addr = r_row;
  assign wr_addr = r_row;
  assign fus_img = r_fus_img;
  assign fus_ovl = r_fus_ovl;

  // --------------------------------------------------------------------------
  // Row counter: cleared on frame start, advanced only on an accepted write
  // that is not the last row, so it never exceeds ROWS-1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_row <= '0;
    end else if (w_accept && !w_last_row) begin
      r_row <= r_row + ADDR_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Read-latency wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_RD) begin
      r_cnt <= c_cnt_init;
    end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Fusion input holding registers. Loaded once per row and otherwise held,
  // which keeps them stable through write backpressure and after frame end.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fus_img <= '0;
      r_fus_ovl <= '0;
    end else if (w_capture) begin
      r_fus_img <= img_rdata;
      r_fus_ovl <= ovl_rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fusion_row_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fusion_row_sequencer
//  Purpose  : Self-checking bench. Unit 0 is a 32-row, latency-1 sequencer;
//             unit 1 is a 4-row, latency-3 sequencer. A timeline model of
//             the frame (row r reads at base, writes after RD_LAT wait cycles)
//             is compared against both units on every falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fusion_row_sequencer;

  localparam int DW = 512;
  localparam int AW = 5;
  localparam logic [DW-1:0] JUNK = {16{32'hDEADBEEF}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // unit 0 signals
  logic          start0, busy0, done0, rd_en0, wr_en0, wr_ready0;
  logic [AW-1:0] rd_addr0, wr_addr0;
  logic [DW-1:0] img_rd0, ovl_rd0, fus_img0, fus_ovl0, fus_res0, wr_data0;
  // unit 1 signals
  logic          start1, busy1, done1, rd_en1, wr_en1, wr_ready1;
  logic [AW-1:0] rd_addr1, wr_addr1;
  logic [DW-1:0] img_rd1, ovl_rd1, fus_img1, fus_ovl1, fus_res1, wr_data1;

  int cyc      = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int ovl_mul  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- environment: memories and fusion datapath --------------
  function automatic logic [DW-1:0] img_row(input int u, input int r);
    logic [7:0] v;
    v = (u == 0) ? 8'(r) : 8'(r + 160);
    return {64{v}};
  endfunction

  function automatic logic [DW-1:0] ovl_row(input int u, input int r);
    logic [7:0] v;
    v = (u == 0) ? 8'(r * ovl_mul) : 8'(r * 7 + 3);
    return {64{v}};
  endfunction

  // Per pixel: img + ovl/2, saturating at 255.
  function automatic logic [DW-1:0] fuse(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] res;
    logic [8:0]    s;
    for (int p = 0; p < 64; p++) begin
      s = {1'b0, a[p*8 +: 8]} + {2'b00, b[p*8+1 +: 7]};
      res[p*8 +: 8] = s[8] ? 8'hFF : s[7:0];
    end
    return res;
  endfunction

  assign fus_res0 = fuse(fus_img0, fus_ovl0);
  assign fus_res1 = fuse(fus_img1, fus_ovl1);

  // Read data is only meaningful exactly RD_LAT cycles after rd_en.
  always @(posedge clk) begin
    img_rd0 <= rd_en0 ? img_row(0, int'(rd_addr0)) : JUNK;
    ovl_rd0 <= rd_en0 ? ovl_row(0, int'(rd_addr0)) : JUNK;
  end

  logic [DW-1:0] s_img1 [2];
  logic [DW-1:0] s_ovl1 [2];
  always @(posedge clk) begin
    s_img1[0] <= rd_en1 ? img_row(1, int'(rd_addr1)) : JUNK;
    s_ovl1[0] <= rd_en1 ? ovl_row(1, int'(rd_addr1)) : JUNK;
    s_img1[1] <= s_img1[0];
    s_ovl1[1] <= s_ovl1[0];
    img_rd1   <= s_img1[1];
    ovl_rd1   <= s_ovl1[1];
  end

  // ---------------- DUTs ----------------------------------------------------
  fusion_row_sequencer #(.ROWS(32), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
    .rd_en(rd_en0), .rd_addr(rd_addr0), .img_rdata(img_rd0), .ovl_rdata(ovl_rd0),
    .fus_img(fus_img0), .fus_ovl(fus_ovl0), .fus_result(fus_res0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .wr_ready(wr_ready0)
  );

  fusion_row_sequencer #(.ROWS(4), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .rd_en(rd_en1), .rd_addr(rd_addr1), .img_rdata(img_rd1), .ovl_rdata(ovl_rd1),
    .fus_img(fus_img1), .fus_ovl(fus_ovl1), .fus_result(fus_res1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .wr_ready(wr_ready1)
  );

  // ---------------- checking ------------------------------------------------
  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
  endtask

  // Timeline model state per unit
  int            rows_p  [2] = '{32, 4};
  int            lat_p   [2] = '{1, 3};
  bit            act     [2] = '{0, 0};
  int            mrow    [2] = '{0, 0};
  int            base    [2] = '{0, 0};
  int            done_at [2] = '{-1, -1};
  logic [DW-1:0] mfi     [2] = '{'0, '0};
  logic [DW-1:0] mfo     [2] = '{'0, '0};

  task automatic model_step(input int u, input logic busy, input logic done,
                            input logic rd_en, input logic wr_en,
                            input logic [AW-1:0] rd_addr, input logic [AW-1:0] wr_addr,
                            input logic [DW-1:0] wr_data, input logic [DW-1:0] fi,
                            input logic [DW-1:0] fo, input logic start, input logic wr_ready);
    string p;
    p = (u == 0) ? "u0" : "u1";
    if (!rst_n) begin
      chk({p, " rst ctl"}, DW'({busy, done, rd_en, wr_en, rd_addr, wr_addr}), '0);
      chk({p, " rst wr_data"}, wr_data, '0);
      chk({p, " rst fus_img"}, fi, '0);
      chk({p, " rst fus_ovl"}, fo, '0);
      act[u] = 1'b0; done_at[u] = -1; mfi[u] = '0; mfo[u] = '0;
    end else if (done_at[u] == cyc) begin
      chk({p, " done ctl"}, DW'({busy, done, rd_en, wr_en}), DW'(4'b1100));
      chk({p, " done fus_img"}, fi, mfi[u]);
      chk({p, " done fus_ovl"}, fo, mfo[u]);
      done_at[u] = -1;
    end else if (act[u]) begin
      chk({p, " busy/done"}, DW'({busy, done}), DW'(2'b10));
      if (cyc == base[u]) begin
        chk({p, " rd ctl"}, DW'({rd_en, wr_en}), DW'(2'b10));
        chk({p, " rd_addr"}, DW'(rd_addr), DW'(mrow[u]));
        chk({p, " rd fus_img"}, fi, mfi[u]);
      end else if (cyc <= base[u] + lat_p[u]) begin
        chk({p, " wait ctl"}, DW'({rd_en, wr_en}), '0);
        chk({p, " wait fus_img"}, fi, mfi[u]);
      end else begin
        mfi[u] = img_row(u, mrow[u]);
        mfo[u] = ovl_row(u, mrow[u]);
        chk({p, " wr ctl"}, DW'({rd_en, wr_en}), DW'(2'b01));
        chk({p, " wr_addr"}, DW'(wr_addr), DW'(mrow[u]));
        chk({p, " wr fus_img"}, fi, mfi[u]);
        chk({p, " wr fus_ovl"}, fo, mfo[u]);
        chk({p, " wr_data"}, wr_data, fuse(mfi[u], mfo[u]));
        if (wr_ready) begin
          mrow[u]++;
          if (mrow[u] == rows_p[u]) begin
            act[u] = 1'b0;
            done_at[u] = cyc + 1;
          end else begin
            base[u] = cyc + 1;
          end
        end
      end
    end else begin
      chk({p, " idle ctl"}, DW'({busy, done, rd_en, wr_en}), '0);
      chk({p, " idle fus_img"}, fi, mfi[u]);
      chk({p, " idle fus_ovl"}, fo, mfo[u]);
      if (start) begin
        act[u] = 1'b1; mrow[u] = 0; base[u] = cyc + 1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step(0, busy0, done0, rd_en0, wr_en0, rd_addr0, wr_addr0, wr_data0,
               fus_img0, fus_ovl0, start0, wr_ready0);
    model_step(1, busy1, done1, rd_en1, wr_en1, rd_addr1, wr_addr1, wr_data1,
               fus_img1, fus_ovl1, start1, wr_ready1);
  end

  // ---------------- stimulus ------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one unit-0 frame. stall_row gets wr_ready low for 4 cycles;
  // poke pulses start mid-frame and holds it from the done cycle onward.
  task automatic run_frame0(input int stall_row, input bit poke, input int cap_row,
                            output int first_rd, output int done_c, output int nwr,
                            output logic [DW-1:0] cap);
    int stall_left;
    bit stalled;
    stall_left = 0; stalled = 0;
    first_rd = -1; done_c = -1; nwr = 0; cap = '0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 0; k < 400 && done_c < 0; k++) begin
      if (rd_en0 && first_rd < 0) first_rd = cyc;
      if (wr_en0 && int'(wr_addr0) == stall_row && !stalled) begin
        stalled = 1; stall_left = 4;
      end
      wr_ready0 = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      if (wr_en0 && wr_ready0) begin
        nwr++;
        if (int'(wr_addr0) == cap_row) cap = wr_data0;
      end
      start0 = poke && rd_en0 && (rd_addr0 == AW'(10));
      if (done0) begin
        done_c = cyc;
        start0 = poke;
      end
      tick();
    end
    wr_ready0 = 1'b1;
    chk("frame0 completes", DW'(done_c < 0), '0);
  endtask

  int            fr, dc, nw, seen;
  logic [DW-1:0] cap;
  int            rdq [$];

  initial begin
    start0 = 1'b1; start1 = 1'b1; wr_ready0 = 1'b1; wr_ready1 = 1'b1;

    // 1: reset with start held high
    rst_n = 1'b0;
    repeat (3) tick();
    chk("reset busy0", DW'(busy0), '0);
    chk("reset fus_img0", fus_img0, '0);
    start0 = 1'b0; start1 = 1'b0;
    rst_n = 1'b1;
    repeat (5) tick();

    // 2: full frame, ovl = 0
    ovl_mul = 0;
    run_frame0(-1, 0, 5, fr, dc, nw, cap);
    chk("frame span", DW'(dc - fr), DW'(96));
    chk("frame writes", DW'(nw), DW'(32));
    chk("row5 wr_data", cap, {64{8'h05}});
    chk("busy after done", DW'(busy0), '0);
    repeat (3) tick();

    // 3: backpressure on row 7
    ovl_mul = 5;
    run_frame0(7, 0, 3, fr, dc, nw, cap);
    chk("stall span", DW'(dc - fr), DW'(100));
    chk("stall writes", DW'(nw), DW'(32));
    chk("row3 wr_data", cap, {64{8'h0A}});
    repeat (2) tick();

    // 4: start during frame and DONE ignored; start right after DONE restarts
    run_frame0(-1, 1, 31, fr, dc, nw, cap);
    chk("poke span", DW'(dc - fr), DW'(96));
    chk("poke writes", DW'(nw), DW'(32));
    chk("idle after done", DW'(busy0), '0);
    tick();
    start0 = 1'b0;
    chk("restart rd", DW'({rd_en0, rd_addr0}), DW'({1'b1, 5'd0}));
    chk("restart cycle", DW'(cyc - dc), DW'(2));

    // 5: reset during WR of row 12
    seen = 0;
    for (int k = 0; k < 200 && seen == 0; k++) begin
      if (wr_en0 && wr_addr0 == AW'(12)) seen = 1;
      else tick();
    end
    chk("reached row12 WR", DW'(seen), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ctl", DW'({busy0, done0, rd_en0, wr_en0, rd_addr0, wr_addr0}), '0);
    chk("async rst data", wr_data0 | fus_img0 | fus_ovl0, '0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (done0 || wr_en0 || rd_en0) seen++;
      tick();
    end
    chk("no activity after abort", DW'(seen), '0);
    run_frame0(-1, 0, 3, fr, dc, nw, cap);
    chk("post-abort span", DW'(dc - fr), DW'(96));
    chk("post-abort writes", DW'(nw), DW'(32));
    chk("post-abort row3", cap, {64{8'h0A}});
    repeat (2) tick();

    // 6: RD_LAT=3, ROWS=4 unit
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    dc = -1; nw = 0; cap = '0;
    for (int k = 0; k < 100 && dc < 0; k++) begin
      if (rd_en1) rdq.push_back(cyc);
      if (wr_en1 && wr_ready1) begin
        nw++;
        if (wr_addr1 == AW'(2)) cap = wr_data1;
      end
      if (done1) dc = cyc;
      tick();
    end
    chk("lat3 rd count", DW'(rdq.size()), DW'(4));
    for (int i = 1; i < rdq.size(); i++) chk("lat3 rd spacing", DW'(rdq[i] - rdq[i-1]), DW'(5));
    if (rdq.size() > 0) chk("lat3 span", DW'(dc - rdq[0]), DW'(20));
    chk("lat3 writes", DW'(nw), DW'(4));
    chk("lat3 row2 wr_data", cap, {64{8'hAA}});
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
